wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port (A3/WD3/WE3). Shares it between the in-order

---
 rtl/wb_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback source select plus a small FIFO of
// multi-cycle (mul/div) results, with starvation-bounded forcing of the buffered results.
module wb_port_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_valid,
   input  logic [AW-1:0] pipe_rd,
   input  logic [1:0]    pipe_sel,
   input  logic [DW-1:0] pipe_res,
   input  logic [DW-1:0] pipe_pc4,
   input  logic [DW-1:0] pipe_imm,
   output logic          pipe_stall,
   input  logic          mc_valid,
   input  logic [AW-1:0] mc_rd,
   input  logic [DW-1:0] mc_data,
   output logic          mc_ready,
   output logic          we3,
   output logic [AW-1:0] a3,
   output logic [DW-1:0] wd3
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
   localparam logic [SW-1:0]    STARVE_C = SW'(STARVE_MAX);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_PEND  = 2'd1;
   localparam logic [1:0] S_FORCE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic             we3_q, we3_d;
   logic [AW-1:0]    a3_q, a3_d;
   logic [DW-1:0]    wd3_q, wd3_d;

   logic [AW-1:0]    rd_mem   [BUF_DEPTH];
   logic [DW-1:0]    data_mem [BUF_DEPTH];

   logic             push;
   logic             head_grant;
   logic             pipe_grant;
   logic [DW-1:0]    pipe_data;
   logic [AW-1:0]    head_rd;
   logic [DW-1:0]    head_data;

   // mc_ready is derived only from registered state so the mc unit never sees a loop
   assign mc_ready   = (count_q < DEPTH_C) & ~rst;
   assign push       = mc_valid & mc_ready;
   assign pipe_stall = ~rst & (state_q == S_FORCE) & pipe_valid;
   assign head_grant = ~rst & (count_q != '0) &
                       ((state_q == S_FORCE) | ((state_q == S_PEND) & ~pipe_valid));
   assign pipe_grant = pipe_valid & ~pipe_stall & ~head_grant;
   assign head_rd    = rd_mem[head_q];
   assign head_data  = data_mem[head_q];

   always_comb begin
      pipe_data = pipe_res;
      case (pipe_sel)
         2'b01:   pipe_data = pipe_pc4;
         2'b10:   pipe_data = pipe_imm;
         default: pipe_data = pipe_res;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      starve_d = starve_q;
      head_d   = head_q;
      tail_d   = tail_q;
      state_d  = state_q;

      if (push && !head_grant) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && head_grant) begin
         count_d = count_q - CNT_W'(1);
      end

      if (push) begin
         tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
      end
      if (head_grant) begin
         head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
      end

      if (head_grant) begin
         starve_d = '0;
      end else if ((count_q != '0) && pipe_grant && (starve_q != STARVE_C)) begin
         starve_d = starve_q + SW'(1);
      end

      // Once forced, the buffer drains completely before the pipeline regains priority
      if (count_d == '0) begin
         state_d = S_EMPTY;
      end else if (state_q == S_FORCE) begin
         state_d = S_FORCE;
      end else if ((starve_d == STARVE_C) || (count_d == DEPTH_C)) begin
         state_d = S_FORCE;
      end else begin
         state_d = S_PEND;
      end
   end

   // rd==0 is consumed like any other grant but must never reach the register file
   always_comb begin
      we3_d = 1'b0;
      a3_d  = a3_q;
      wd3_d = wd3_q;
      if (head_grant) begin
         if (head_rd != '0) begin
            we3_d = 1'b1;
            a3_d  = head_rd;
            wd3_d = head_data;
         end else begin
            a3_d  = '0;
            wd3_d = '0;
         end
      end else if (pipe_grant) begin
         if (pipe_rd != '0) begin
            we3_d = 1'b1;
            a3_d  = pipe_rd;
            wd3_d = pipe_data;
         end else begin
            a3_d  = '0;
            wd3_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_EMPTY;
         count_q  <= '0;
         starve_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         we3_q    <= 1'b0;
         a3_q     <= '0;
         wd3_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         we3_q    <= we3_d;
         a3_q     <= a3_d;
         wd3_q    <= wd3_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[tail_q]   <= mc_rd;
         data_mem[tail_q] <= mc_data;
      end
   end

   assign we3 = we3_q;
   assign a3  = a3_q;
   assign wd3 = wd3_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: each cycle's expected write is queued when the
// stimulus is driven and compared after the clock edge that should produce it.
module tb_wb_port_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
   } wrExp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipeValid;
   logic [4:0]  pipeRd;
   logic [1:0]  pipeSel;
   logic [31:0] pipeRes;
   logic [31:0] pipePc4;
   logic [31:0] pipeImm;
   logic        pipeStall;
   logic        mcValid;
   logic [4:0]  mcRd;
   logic [31:0] mcData;
   logic        mcReady;
   logic        we3;
   logic [4:0]  a3;
   logic [31:0] wd3;

   int          vecCount  = 0;
   int          missCount = 0;
   wrExp_t      expQ [$];
   logic [4:0]  holdA3 = '0;
   logic [31:0] holdWd = '0;

   wb_port_arbiter #(
      .DW(32), .AW(5), .BUF_DEPTH(2), .STARVE_MAX(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_valid (pipeValid),
      .pipe_rd    (pipeRd),
      .pipe_sel   (pipeSel),
      .pipe_res   (pipeRes),
      .pipe_pc4   (pipePc4),
      .pipe_imm   (pipeImm),
      .pipe_stall (pipeStall),
      .mc_valid   (mcValid),
      .mc_rd      (mcRd),
      .mc_data    (mcData),
      .mc_ready   (mcReady),
      .we3        (we3),
      .a3         (a3),
      .wd3        (wd3)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required $finish)");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic setPipe(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [31:0] res);
      pipeValid = v;
      pipeRd    = rd;
      pipeSel   = sel;
      pipeRes   = res;
   endtask

   task automatic setMc(input logic v, input logic [4:0] rd, input logic [31:0] data);
      mcValid = v;
      mcRd    = rd;
      mcData  = data;
   endtask

   // kind: 0 = no write (a3/wd3 hold), 1 = write ea3/ewd, 2 = outputs all zero
   task automatic applyStimulus(input logic expStall, input logic expReady, input int kind,
                                input logic [4:0] ea3, input logic [31:0] ewd);
      wrExp_t e;
      wrExp_t got;
      #1;
      checkOutput("pipe_stall", 64'(pipeStall), 64'(expStall));
      checkOutput("mc_ready", 64'(mcReady), 64'(expReady));
      if (kind == 1) begin
         holdA3 = ea3;
         holdWd = ewd;
         e = '{we: 1'b1, a3: ea3, wd: ewd};
      end else if (kind == 2) begin
         holdA3 = '0;
         holdWd = '0;
         e = '{we: 1'b0, a3: 5'd0, wd: 32'd0};
      end else begin
         e = '{we: 1'b0, a3: holdA3, wd: holdWd};
      end
      expQ.push_back(e);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checkOutput("we3", 64'(we3), 64'(got.we));
      checkOutput("a3", 64'(a3), 64'(got.a3));
      checkOutput("wd3", 64'(wd3), 64'(got.wd));
   endtask

   initial begin
      pipePc4 = 32'h104;
      pipeImm = 32'h1234_5000;
      setPipe(1'b0, 5'd0, 2'b00, 32'h0);

      // reset holds everything quiet even with a presented mc result
      rst = 1'b1;
      setMc(1'b1, 5'd3, 32'h55);
      applyStimulus(1'b0, 1'b0, 2, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b0, 2, 5'd0, 32'h0);
      rst = 1'b0;
      setMc(1'b0, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);

      // pipeline source select
      setPipe(1'b1, 5'd5, 2'b01, 32'hAA);
      applyStimulus(1'b0, 1'b1, 1, 5'd5, 32'h104);
      setPipe(1'b1, 5'd5, 2'b10, 32'hAA);
      applyStimulus(1'b0, 1'b1, 1, 5'd5, 32'h1234_5000);
      setPipe(1'b1, 5'd5, 2'b00, 32'hAA);
      applyStimulus(1'b0, 1'b1, 1, 5'd5, 32'hAA);
      setPipe(1'b1, 5'd9, 2'b11, 32'hBB);
      applyStimulus(1'b0, 1'b1, 1, 5'd9, 32'hBB);

      // idle-pipeline mc result: pushed, then written the following cycle
      setPipe(1'b0, 5'd0, 2'b00, 32'h0);
      setMc(1'b1, 5'd7, 32'hDEAD);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);
      setMc(1'b0, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1, 5'd7, 32'hDEAD);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);

      // starvation: pipeline wins four PEND cycles, then the head is forced
      setMc(1'b1, 5'd11, 32'hB0B);
      setPipe(1'b1, 5'd1, 2'b00, 32'h100);
      applyStimulus(1'b0, 1'b1, 1, 5'd1, 32'h100);
      setMc(1'b0, 5'd0, 32'h0);
      for (int i = 2; i <= 5; i++) begin
         setPipe(1'b1, 5'(i), 2'b00, 32'(i * 256));
         applyStimulus(1'b0, 1'b1, 1, 5'(i), 32'(i * 256));
      end
      setPipe(1'b1, 5'd6, 2'b00, 32'h600);
      applyStimulus(1'b1, 1'b1, 1, 5'd11, 32'hB0B);
      applyStimulus(1'b0, 1'b1, 1, 5'd6, 32'h600);

      // full buffer forces back-to-back drain, including a same-cycle push and pop
      setMc(1'b1, 5'd13, 32'hD1);
      setPipe(1'b1, 5'd12, 2'b00, 32'hC00);
      applyStimulus(1'b0, 1'b1, 1, 5'd12, 32'hC00);
      setMc(1'b1, 5'd14, 32'hD2);
      setPipe(1'b1, 5'd15, 2'b00, 32'hF00);
      applyStimulus(1'b0, 1'b1, 1, 5'd15, 32'hF00);
      setMc(1'b1, 5'd16, 32'hD3);
      setPipe(1'b1, 5'd17, 2'b00, 32'h1700);
      applyStimulus(1'b1, 1'b0, 1, 5'd13, 32'hD1);
      applyStimulus(1'b1, 1'b1, 1, 5'd14, 32'hD2);
      setMc(1'b0, 5'd0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1, 5'd16, 32'hD3);
      applyStimulus(1'b0, 1'b1, 1, 5'd17, 32'h1700);

      // rd==0 from both sources is consumed without a write
      setPipe(1'b0, 5'd0, 2'b00, 32'h0);
      setMc(1'b1, 5'd0, 32'hFFFF);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);
      setMc(1'b0, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b1, 2, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);
      setPipe(1'b1, 5'd8, 2'b00, 32'h88);
      applyStimulus(1'b0, 1'b1, 1, 5'd8, 32'h88);
      setPipe(1'b1, 5'd0, 2'b00, 32'h77);
      applyStimulus(1'b0, 1'b1, 2, 5'd0, 32'h0);

      // reset with a full buffer discards both entries
      setMc(1'b1, 5'd21, 32'h21);
      setPipe(1'b1, 5'd20, 2'b00, 32'h14);
      applyStimulus(1'b0, 1'b1, 1, 5'd20, 32'h14);
      setMc(1'b1, 5'd22, 32'h22);
      setPipe(1'b1, 5'd23, 2'b00, 32'h17);
      applyStimulus(1'b0, 1'b1, 1, 5'd23, 32'h17);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 2, 5'd0, 32'h0);
      rst = 1'b0;
      setMc(1'b0, 5'd0, 32'h0);
      setPipe(1'b0, 5'd0, 2'b00, 32'h0);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);
      applyStimulus(1'b0, 1'b1, 0, 5'd0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
